// File: rtl/ahb_to_fpga_sram_ctrl.sv
// AHB-Lite slave driving an FPGA block-RAM port: zero wait states, 1-entry write buffer.
// Define AHB_SRAM_CTRL_ALIGN_ERR_EN to answer unaligned/oversize transfers with ERROR.
module ahb_to_fpga_sram_ctrl #(
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWREN,
  output logic          SRAMCS
);

  logic          req;
  logic          bad;
  logic          acc;
  logic          rd_acc;
  logic          wr_acc;
  logic [3:0]    mask;

  logic          ph_rd;
  logic          ph_wr;
  logic [AW-1:0] ph_addr;
  logic [3:0]    ph_mask;

  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;

  logic          cap;
  logic          direct;
  logic          drain;
  logic          hit;

  logic          unused;
  assign unused = ^{HADDR[31:AW+2], HTRANS[0]};

  assign req    = HSEL & HREADY & HTRANS[1];
  assign acc    = req & ~bad;
  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;

  // a pending write data phase loses the port to a new read
  assign cap    = ph_wr & rd_acc;
  assign direct = ph_wr & ~rd_acc;
  assign drain  = buf_valid & ~rd_acc & ~ph_wr;
  assign hit    = buf_valid & (buf_addr == ph_addr);

  // byte lanes touched by the transfer
  always_comb begin
    mask = 4'b1111;
    unique case (1'b1)
      HSIZE == 3'd0: mask = 4'b0001 << HADDR[1:0];
      HSIZE == 3'd1: mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default:       mask = 4'b1111;
    endcase
  end

  // register address-phase info when the bus advances
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ph_rd   <= 1'b0;
      ph_wr   <= 1'b0;
      ph_addr <= '0;
      ph_mask <= '0;
    end else if (HREADY) begin
      ph_rd <= rd_acc;
      ph_wr <= wr_acc;
      if (acc) begin
        ph_addr <= HADDR[AW+1:2];
        ph_mask <= mask;
      end
    end
  end

  // write buffer: fill on port conflict, empty when the port is free
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else if (cap) begin
      buf_valid <= 1'b1;
      buf_addr  <= ph_addr;
      buf_mask  <= ph_mask;
      buf_data  <= HWDATA;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // SRAM port arbitration: read, then direct write, then drain
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMADDR  = '0;
    SRAMWDATA = '0;
    SRAMWREN  = '0;
    unique case (1'b1)
      rd_acc: begin
        SRAMCS   = 1'b1;
        SRAMADDR = HADDR[AW+1:2];
      end
      direct: begin
        SRAMCS    = 1'b1;
        SRAMADDR  = ph_addr;
        SRAMWDATA = HWDATA;
        SRAMWREN  = ph_mask;
      end
      drain: begin
        SRAMCS    = 1'b1;
        SRAMADDR  = buf_addr;
        SRAMWDATA = buf_data;
        SRAMWREN  = buf_mask;
      end
      default: ;
    endcase
  end

  // read data: buffered bytes override stale SRAM bytes
  always_comb begin
    HRDATA = '0;
    if (ph_rd) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (hit && buf_mask[i]) ?
          buf_data[8*i +: 8] : SRAMRDATA[8*i +: 8];
      end
    end
  end

`ifdef AHB_SRAM_CTRL_ALIGN_ERR_EN
  typedef enum logic [1:0] {
    S_OK,
    S_ERR1,
    S_ERR2
  } err_t;

  err_t st;
  logic hready_q;
  logic hresp_q;

  assign bad = (HSIZE > 3'd2) ||
               (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) ||
               (HSIZE == 3'd1 && HADDR[0]);

  // two-cycle ERROR response for rejected transfers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st       <= S_OK;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      unique case (st)
        S_ERR1: begin
          st       <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          if (req && bad) begin
            st       <= S_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= 1'b1;
          end else begin
            st       <= S_OK;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
`else
  assign bad       = 1'b0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  // the buffer is always drained before the next conflict
  a_no_overwrite: assert property (
    @(posedge CLK) disable iff (RESET) !(cap && buf_valid)
  );

endmodule

// File: tb/tb_ahb_to_fpga_sram_ctrl.sv
// Directed bench for ahb_to_fpga_sram_ctrl with an SRAM model and read scoreboard.
// Honours AHB_SRAM_CTRL_ALIGN_ERR_EN for the unaligned-write step.
module tb_ahb_to_fpga_sram_ctrl;
  localparam int AW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   SRAMRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWREN;
  logic          SRAMCS;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  logic [31:0] sb[$];
  logic        rd_pend = 1'b0;
  logic [31:0] nxt_wd  = '0;
  logic [31:0] ref_mem [0:255];
  logic [31:0] sram    [0:255];
  logic        loaded  = 1'b0;

  logic          s_cs;
  logic          s_hrdy;
  logic          s_hresp;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_wren;
  logic [31:0]   s_wdata;
  logic [31:0]   s_hrdata;

  always #5 CLK = ~CLK;

  assign HREADY = HREADYOUT;

  ahb_to_fpga_sram_ctrl #(.AW(AW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .SRAMRDATA (SRAMRDATA),
    .SRAMADDR  (SRAMADDR),
    .SRAMWDATA (SRAMWDATA),
    .SRAMWREN  (SRAMWREN),
    .SRAMCS    (SRAMCS)
  );

  function automatic logic [31:0] pat(int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  // block-RAM model: registered read, byte-enabled write
  always @(posedge CLK) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) sram[i] <= pat(i);
      loaded <= 1'b1;
    end else if (SRAMCS) begin
      if (SRAMWREN == 4'b0000) SRAMRDATA <= sram[SRAMADDR[7:0]];
      for (int i = 0; i < 4; i++)
        if (SRAMWREN[i])
          sram[SRAMADDR[7:0]][8*i +: 8] <= SRAMWDATA[8*i +: 8];
    end
  end

  function automatic bit bad(logic [31:0] a, logic [2:0] sz);
    bit b;
    b = (sz > 3'd2) || (sz == 3'd2 && a[1:0] != 2'b00) ||
        (sz == 3'd1 && a[0]);
`ifdef AHB_SRAM_CTRL_ALIGN_ERR_EN
    return b;
`else
    return b & 1'b0;
`endif
  endfunction

  function automatic logic [3:0] ref_mask(logic [31:0] a, logic [2:0] sz);
    if (sz == 3'd0) begin
      case (a[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (sz == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = '0;
    HSIZE  = 3'd0;
  endtask

  task automatic wr(logic [31:0] a, logic [2:0] sz, logic [31:0] d);
    logic [3:0] m;
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = a;
    HSIZE  = sz;
    nxt_wd = d;
    if (!bad(a, sz)) begin
      m = ref_mask(a, sz);
      for (int i = 0; i < 4; i++)
        if (m[i]) ref_mem[a[9:2]][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic rd(logic [31:0] a, logic [2:0] sz);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = a;
    HSIZE  = sz;
    if (!bad(a, sz)) sb.push_back(ref_mem[a[9:2]]);
  endtask

  // one bus cycle: sample mid-cycle, score reads, then advance
  task automatic cyc();
    logic [31:0] e;
    @(negedge CLK);
    if (rd_pend) begin
      if (sb.size() == 0) begin
        n_total++;
        n_fail++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e = sb.pop_front();
        chk("hrdata", HRDATA, e);
      end
    end
    s_cs     = SRAMCS;
    s_hrdy   = HREADYOUT;
    s_hresp  = HRESP;
    s_addr   = SRAMADDR;
    s_wren   = SRAMWREN;
    s_wdata  = SRAMWDATA;
    s_hrdata = HRDATA;
    rd_pend  = HSEL && HREADY && HTRANS[1] && !HWRITE &&
               !bad(HADDR, HSIZE);
    @(posedge CLK);
    #1;
    HWDATA = nxt_wd;
    nxt_wd = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    RESET  = 1'b1;
    HWDATA = '0;
    idle();
    cyc();
    cyc();
    chk("rst_hreadyout", 32'(s_hrdy), 32'd1);
    chk("rst_hresp", 32'(s_hresp), 32'd0);
    chk("rst_hrdata", s_hrdata, 32'd0);
    chk("rst_cs", 32'(s_cs), 32'd0);
    chk("rst_wren", 32'(s_wren), 32'd0);
    RESET = 1'b0;

    // word write then read back
    wr(32'h100, 3'd2, 32'hDEAD_BEEF);
    cyc();
    idle();
    cyc();
    chk("t1_cs", 32'(s_cs), 32'd1);
    chk("t1_addr", 32'(s_addr), 32'h40);
    chk("t1_wren", 32'(s_wren), 32'hF);
    chk("t1_wdata", s_wdata, 32'hDEAD_BEEF);
    cyc();
    rd(32'h100, 3'd2);
    cyc();
    chk("t1_rd_cs", 32'(s_cs), 32'd1);
    chk("t1_rd_addr", 32'(s_addr), 32'h40);
    chk("t1_rd_wren", 32'(s_wren), 32'd0);
    idle();
    cyc();
    chk("t1_hresp", 32'(s_hresp), 32'd0);

    // byte write buffered behind an immediate read
    wr(32'h100, 3'd2, 32'h1122_3344);
    cyc();
    idle();
    cyc();
    cyc();
    wr(32'h103, 3'd0, 32'hAA00_0000);
    cyc();
    rd(32'h100, 3'd2);
    cyc();
    chk("t2_rd_wins_wren", 32'(s_wren), 32'd0);
    chk("t2_rd_cs", 32'(s_cs), 32'd1);
    idle();
    cyc();
    chk("t2_merged", s_hrdata, 32'hAA22_3344);
    chk("t2_drain_wren", 32'(s_wren), 32'h8);
    chk("t2_drain_addr", 32'(s_addr), 32'h40);
    chk("t2_drain_byte", 32'(s_wdata[31:24]), 32'hAA);
    cyc();
    chk("t2_idle_cs", 32'(s_cs), 32'd0);
    rd(32'h100, 3'd2);
    cyc();
    idle();
    cyc();

    // back-to-back W0 W4 R4 R0
    wr(32'h0, 3'd2, 32'h0102_0304);
    cyc();
    wr(32'h4, 3'd2, 32'h0506_0708);
    cyc();
    chk("t3_w0_wren", 32'(s_wren), 32'hF);
    chk("t3_w0_addr", 32'(s_addr), 32'h0);
    chk("t3_hready", 32'(s_hrdy), 32'd1);
    rd(32'h4, 3'd2);
    cyc();
    chk("t3_w4_held", 32'(s_wren), 32'd0);
    chk("t3_r4_addr", 32'(s_addr), 32'h1);
    rd(32'h0, 3'd2);
    cyc();
    chk("t3_r4_data", s_hrdata, 32'h0506_0708);
    chk("t3_r0_wren", 32'(s_wren), 32'd0);
    idle();
    cyc();
    chk("t3_r0_data", s_hrdata, 32'h0102_0304);
    chk("t3_drain_wren", 32'(s_wren), 32'hF);
    chk("t3_drain_addr", 32'(s_addr), 32'h1);
    chk("t3_drain_wdata", s_wdata, 32'h0506_0708);
    rd(32'h4, 3'd2);
    cyc();
    idle();
    cyc();

    // halfword write, upper half
    wr(32'h202, 3'd1, 32'h5566_0000);
    cyc();
    idle();
    cyc();
    chk("t4_wren", 32'(s_wren), 32'hC);
    chk("t4_addr", 32'(s_addr), 32'h80);
    rd(32'h200, 3'd2);
    cyc();
    idle();
    cyc();
    chk("t4_hrdata", s_hrdata, 32'h5566_0080);

    // reset with a buffered write pending
    wr(32'h300, 3'd2, 32'h1234_5678);
    cyc();
    rd(32'h10, 3'd2);
    cyc();
    rd(32'h14, 3'd2);
    cyc();
    RESET = 1'b1;
    idle();
    sb.delete();
    rd_pend = 1'b0;
    #1;
    chk("t5_async_wren", 32'(SRAMWREN), 32'd0);
    chk("t5_async_cs", 32'(SRAMCS), 32'd0);
    cyc();
    chk("t5_hready", 32'(s_hrdy), 32'd1);
    chk("t5_hresp", 32'(s_hresp), 32'd0);
    chk("t5_hrdata", s_hrdata, 32'd0);
    RESET = 1'b0;
    cyc();
    chk("t5_discard_wren", 32'(s_wren), 32'd0);
    chk("t5_discard_cs", 32'(s_cs), 32'd0);
    ref_mem[8'hC0] = pat(32'hC0);
    rd(32'h300, 3'd2);
    cyc();
    idle();
    cyc();

    // unaligned word write
    wr(32'h102, 3'd2, 32'hCAFE_BABE);
    cyc();
`ifdef AHB_SRAM_CTRL_ALIGN_ERR_EN
    chk("t6_addr_cs", 32'(s_cs), 32'd0);
    idle();
    cyc();
    chk("t6_e1_hready", 32'(s_hrdy), 32'd0);
    chk("t6_e1_hresp", 32'(s_hresp), 32'd1);
    chk("t6_e1_cs", 32'(s_cs), 32'd0);
    cyc();
    chk("t6_e2_hready", 32'(s_hrdy), 32'd1);
    chk("t6_e2_hresp", 32'(s_hresp), 32'd1);
    chk("t6_e2_cs", 32'(s_cs), 32'd0);
    cyc();
    chk("t6_ok_hresp", 32'(s_hresp), 32'd0);
    chk("t6_ok_cs", 32'(s_cs), 32'd0);
`else
    idle();
    cyc();
    chk("t6_cs", 32'(s_cs), 32'd1);
    chk("t6_addr", 32'(s_addr), 32'h40);
    chk("t6_wren", 32'(s_wren), 32'hF);
    chk("t6_hresp", 32'(s_hresp), 32'd0);
`endif
    rd(32'h100, 3'd2);
    cyc();
    idle();
    cyc();
    cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
